// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage data-memory controller: 32-bit word loads/stores served from a
// 16-bit SRAM as two half-word accesses, freezing the pipeline while busy.
//
// state | meaning
// IDLE  | no access in flight; ready follows ~(rd_en|wr_en)
// LO    | low half-word access (sram_addr LSB = 0)
// HI    | high half-word access (sram_addr LSB = 1)
// DONE  | access complete; ready=1 for one cycle, then IDLE
module mem_stage_sram_ctrl #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      wait_cnt;
  logic               op_wr;
  logic [SRAM_AW-2:0] idx_q;
  logic [15:0]        wdata_hi;
  logic [31:0]        offset;
  logic [SRAM_AW-2:0] idx;
  logic               req;
  logic               last_cycle;
  logic               unused_addr_bits;

  // Offset wraps modulo 2^32; byte lane bits and bits above the SRAM range drop out.
  assign offset           = address - 32'(BASE_ADDR);
  assign idx              = offset[SRAM_AW:2];
  assign unused_addr_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};
  assign req              = rd_en | wr_en;
  assign last_cycle       = (wait_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = LO;
      LO:      if (last_cycle) state_nxt = HI;
      HI:      if (last_cycle) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    case (state)
      IDLE:    ready = ~req;
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= '0;
      op_wr       <= 1'b0;
      idx_q       <= '0;
      wdata_hi    <= '0;
      rdata       <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            // wr_en wins when both requests are raised together
            op_wr     <= wr_en;
            idx_q     <= idx;
            wdata_hi  <= wdata[31:16];
            wait_cnt  <= CNT_LOAD;
            sram_addr <= {idx, 1'b0};
            if (wr_en) begin
              sram_we_n   <= 1'b0;
              sram_dq_oe  <= 1'b1;
              sram_dq_out <= wdata[15:0];
            end
          end
        end
        LO: begin
          if (last_cycle) begin
            wait_cnt  <= CNT_LOAD;
            sram_addr <= {idx_q, 1'b1};
            if (op_wr) sram_dq_out <= wdata_hi;
            else       rdata[15:0] <= sram_dq_in;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        HI: begin
          if (last_cycle) begin
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            if (!op_wr) rdata[31:16] <= sram_dq_in;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: directed and random word accesses against a
// half-word SRAM model, checked with a word-level reference model.
module tb_mem_stage_sram_ctrl;
  localparam int W    = 2;
  localparam int BASE = 1024;
  localparam int AW   = 18;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rd_en = 1'b0, wr_en = 1'b0;
  logic [31:0]   address = '0, wdata = '0;
  logic [31:0]   rdata;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out;
  logic          sram_dq_oe;
  logic [15:0]   sram_dq_in = '0;
  logic          sram_we_n;

  int total = 0;
  int bad   = 0;

  logic [15:0] sram_mem [int];
  logic [15:0] ref_half [int];
  logic [31:0] ref_rdata = '0;

  mem_stage_sram_ctrl #(.BASE_ADDR(BASE), .WAIT_CYCLES(W), .SRAM_AW(AW)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .wdata(wdata), .rdata(rdata), .ready(ready), .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
    .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  // Power-up contents of any half-word never written
  function automatic logic [15:0] dflt(int h);
    return 16'(h) ^ 16'hA55A;
  endfunction

  always @(posedge clk)
    if (!sram_we_n && sram_dq_oe) sram_mem[int'(sram_addr)] = sram_dq_out;

  always @(negedge clk)
    sram_dq_in = sram_mem.exists(int'(sram_addr)) ? sram_mem[int'(sram_addr)]
                                                  : dflt(int'(sram_addr));

  function automatic int ref_idx(logic [31:0] a);
    logic [31:0] off;
    off = a - 32'(BASE);
    return int'((off / 4) % (32'd1 << (AW - 1)));
  endfunction

  function automatic logic [15:0] ref_h(int h);
    return ref_half.exists(h) ? ref_half[h] : dflt(h);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts at the next negedge with the DUT in IDLE; returns at the DONE negedge.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd);
    int  i;
    logic st;
    i  = ref_idx(a);
    st = wr;
    @(negedge clk);
    rd_en = rd; wr_en = wr; address = a; wdata = wd;
    #1 chk("idle_ready", ready, 0);
    for (int c = 1; c <= 2 * W; c++) begin
      @(negedge clk);
      chk("busy_ready", ready, 0);
      chk("sram_addr", sram_addr, (c <= W) ? 32'(2 * i) : 32'(2 * i + 1));
      chk("we_n", sram_we_n, !st);
      chk("oe", sram_dq_oe, st);
      if (st) chk("dq_out", sram_dq_out, (c <= W) ? wd[15:0] : wd[31:16]);
      rd_en = 1'($urandom); wr_en = 1'($urandom); address = $urandom; wdata = $urandom;
    end
    if (st) begin
      ref_half[2 * i]     = wd[15:0];
      ref_half[2 * i + 1] = wd[31:16];
    end else begin
      ref_rdata = {ref_h(2 * i + 1), ref_h(2 * i)};
    end
    @(negedge clk);
    chk("done_ready", ready, 1);
    chk("done_we_n", sram_we_n, 1);
    chk("done_oe", sram_dq_oe, 0);
    chk("rdata", rdata, ref_rdata);
    rd_en = 1'b1; wr_en = 1'($urandom);
  endtask

  initial begin
    logic [31:0] wd;
    int          i5;

    // Reset asserted mid-cycle
    #3 rst = 1'b1;
    #1;
    chk("rst_rdata", rdata, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_dq_out", sram_dq_out, 0);
    chk("rst_oe", sram_dq_oe, 0);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_ready", ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_norq_ready", ready, 1);

    // Directed store then load
    access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'd1028, 32'h0);
    chk("load_deadbeef", rdata, 32'hDEADBEEF);
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rdata_stable", rdata, 32'hDEADBEEF);
    end

    // Back-to-back store/load to the same word
    wd = $urandom;
    access(1'b0, 1'b1, 32'd1032, wd);
    access(1'b1, 1'b0, 32'd1032, 32'h0);
    chk("b2b_load", rdata, wd);

    // Boundaries: unaligned low bits, and both requests together
    access(1'b1, 1'b0, 32'd1027, 32'h0);
    access(1'b1, 1'b1, 32'd1040, 32'h12345678);
    access(1'b1, 1'b0, 32'd1040, 32'h0);
    chk("both_is_store", rdata, 32'h12345678);

    // Reset during the HI phase of a store
    wd = $urandom;
    i5 = ref_idx(32'd1100);
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b1; address = 32'd1100; wdata = wd;
    for (int c = 1; c <= W + 1; c++) begin
      @(negedge clk);
      rd_en = 1'b0; wr_en = 1'b0;
    end
    chk("hi_we_n_low", sram_we_n, 0);
    #2 rst = 1'b1;
    #1;
    chk("rst_hi_we_n", sram_we_n, 1);
    chk("rst_hi_oe", sram_dq_oe, 0);
    chk("rst_hi_addr", sram_addr, 0);
    chk("rst_hi_dq_out", sram_dq_out, 0);
    chk("rst_hi_rdata", rdata, 0);
    chk("rst_hi_ready", ready, 1);
    ref_half[2 * i5] = wd[15:0];
    ref_rdata = '0;
    @(negedge clk);
    rst = 1'b0;
    access(1'b1, 1'b0, 32'd1100, 32'h0);

    // Random traffic, including addresses that wrap below BASE
    for (int n = 0; n < 24; n++) begin
      logic [1:0]  k;
      logic [31:0] a;
      k = 2'($urandom_range(1, 3));
      a = ($urandom_range(0, 5) == 0) ? $urandom : 32'(BASE + $urandom_range(0, 63));
      access(k[0], k[1], a, $urandom);
    end

    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0;
    #1 chk("final_idle_ready", ready, 1);
    @(negedge clk);
    chk("final_rdata", rdata, ref_rdata);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
